spu_issue_scoreboard: RTL and testbench

//  Dual-issue RAW/WAW scoreboard for the even/odd SPU pipes. It tracks per-register cycles until the
//  in-flight result reaches the forwarding point (FF1..FF7). It decides each cycle whether the even
//  and odd instructions at the issue stage may enter the pipes. It sits between decode and the FF1 stage.

---
 rtl/spu_issue_scoreboard_pkg.sv | 33 +++
 rtl/spu_hazard_chk.sv | 38 +++
 rtl/spu_issue_scoreboard.sv | 121 ++++++++++++
 tb/tb_spu_issue_scoreboard.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/spu_issue_scoreboard_pkg.sv
// Shared constants, unit-id encodings and latency lookup for the SPU dual-issue scoreboard.
// Latency table: 8 nibbles, uid 0 in the most significant nibble, value 0 means result untracked.
package spu_issue_scoreboard_pkg;

    localparam int REG_AW = 7;
    localparam int NREG   = 128;
    localparam int CNT_W  = 3;
    localparam int UID_W  = 3;

    localparam logic RST_ENABLE = 1'b1;

    localparam logic [31:0] LAT_TABLE_DEF = 32'h7642_6262;

    typedef enum logic [UID_W-1:0] {
        UID_DP   = 3'd0,
        UID_SP   = 3'd1,
        UID_FX2  = 3'd2,
        UID_BYTE = 3'd3,
        UID_SHUF = 3'd4,
        UID_LS   = 3'd5,
        UID_PERM = 3'd6,
        UID_CTL  = 3'd7
    } spu_uid_e;

    // Top bit of each nibble is reserved; only values 0..7 are meaningful.
    function automatic logic [CNT_W-1:0] lat_of(input logic [31:0] tbl,
                                                  input logic [UID_W-1:0] uid);
        int base;
        base = 28 - 4 * int'(uid);
        return tbl[base +: CNT_W];
    endfunction

endpackage

// File: rtl/spu_hazard_chk.sv
// Per-slot hazard check: three source RAW compares plus destination WAW check against counters.
// Purely combinational; o_hazard asserted means the slot must not issue this cycle.
module spu_hazard_chk
    import spu_issue_scoreboard_pkg::*;
(
    input  logic [NREG*CNT_W-1:0] i_cnt_flat,
    input  logic [REG_AW-1:0]     i_ra,
    input  logic [REG_AW-1:0]     i_rb,
    input  logic [REG_AW-1:0]     i_rc,
    input  logic [2:0]            i_use,
    input  logic [REG_AW-1:0]     i_rt,
    input  logic                  i_wreg,
    input  logic [CNT_W-1:0]      i_lat,
    output logic                  o_hazard
);

    logic [CNT_W-1:0] w_cnt_ra;
    logic [CNT_W-1:0] w_cnt_rb;
    logic [CNT_W-1:0] w_cnt_rc;
    logic [CNT_W-1:0] w_cnt_rt;
    logic             w_src_haz;
    logic             w_waw_haz;

    assign w_cnt_ra = i_cnt_flat[int'(i_ra) * CNT_W +: CNT_W];
    assign w_cnt_rb = i_cnt_flat[int'(i_rb) * CNT_W +: CNT_W];
    assign w_cnt_rc = i_cnt_flat[int'(i_rc) * CNT_W +: CNT_W];
    assign w_cnt_rt = i_cnt_flat[int'(i_rt) * CNT_W +: CNT_W];

    assign w_src_haz = (i_use[0] && (w_cnt_ra != '0))
                     | (i_use[1] && (w_cnt_rb != '0))
                     | (i_use[2] && (w_cnt_rc != '0));

    // An untracked writer (latency 0) never waits on an older write to the same register.
    assign w_waw_haz = i_wreg && (i_lat != '0) && (w_cnt_rt > i_lat);

    assign o_hazard = w_src_haz | w_waw_haz;

endmodule

// File: rtl/spu_issue_scoreboard.sv
// Dual-issue RAW/WAW scoreboard: per-register countdown to the forwarding point, zero-cycle issue decision.
// Even is older; odd issues only behind a going (or absent) even and never on an intra-pair dependency.
module spu_issue_scoreboard
    import spu_issue_scoreboard_pkg::*;
#(
    parameter logic [31:0] LAT_TABLE = LAT_TABLE_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_hold,
    input  logic        i_flush,
    input  logic        i_iss_valid_e,
    input  logic [6:0]  i_iss_ra_e,
    input  logic [6:0]  i_iss_rb_e,
    input  logic [6:0]  i_iss_rc_e,
    input  logic [2:0]  i_iss_use_e,
    input  logic [6:0]  i_iss_rtaddr_e,
    input  logic        i_iss_wreg_e,
    input  logic [2:0]  i_iss_uid_e,
    input  logic        i_iss_valid_o,
    input  logic [6:0]  i_iss_ra_o,
    input  logic [6:0]  i_iss_rb_o,
    input  logic [6:0]  i_iss_rc_o,
    input  logic [2:0]  i_iss_use_o,
    input  logic [6:0]  i_iss_rtaddr_o,
    input  logic        i_iss_wreg_o,
    input  logic [2:0]  i_iss_uid_o,
    output logic        o_go_e,
    output logic        o_go_o,
    output logic        o_busy_any
);

    logic [CNT_W-1:0]      r_cnt [NREG];
    logic [NREG*CNT_W-1:0] w_cnt_flat;
    logic [CNT_W-1:0]      w_lat_e;
    logic [CNT_W-1:0]      w_lat_o;
    logic                  w_haz_e;
    logic                  w_haz_o;
    logic                  w_pair_dep;
    logic                  w_go_e;
    logic                  w_go_o;
    logic                  w_busy;

    assign w_lat_e = lat_of(LAT_TABLE, i_iss_uid_e);
    assign w_lat_o = lat_of(LAT_TABLE, i_iss_uid_o);

    always_comb begin
        w_cnt_flat = '0;
        w_busy     = 1'b0;
        for (int i = 0; i < NREG; i++) begin
            w_cnt_flat[i*CNT_W +: CNT_W] = r_cnt[i];
            if (r_cnt[i] != '0) begin
                w_busy = 1'b1;
            end
        end
    end

    spu_hazard_chk u_chk_e (
        .i_cnt_flat (w_cnt_flat),
        .i_ra       (i_iss_ra_e),
        .i_rb       (i_iss_rb_e),
        .i_rc       (i_iss_rc_e),
        .i_use      (i_iss_use_e),
        .i_rt       (i_iss_rtaddr_e),
        .i_wreg     (i_iss_wreg_e),
        .i_lat      (w_lat_e),
        .o_hazard   (w_haz_e)
    );

    spu_hazard_chk u_chk_o (
        .i_cnt_flat (w_cnt_flat),
        .i_ra       (i_iss_ra_o),
        .i_rb       (i_iss_rb_o),
        .i_rc       (i_iss_rc_o),
        .i_use      (i_iss_use_o),
        .i_rt       (i_iss_rtaddr_o),
        .i_wreg     (i_iss_wreg_o),
        .i_lat      (w_lat_o),
        .o_hazard   (w_haz_o)
    );

    // Odd depends on even's result or destination: even's write is not yet visible in the counters.
    assign w_pair_dep = i_iss_valid_e && i_iss_wreg_e &&
                        ((i_iss_use_o[0] && (i_iss_ra_o == i_iss_rtaddr_e)) ||
                         (i_iss_use_o[1] && (i_iss_rb_o == i_iss_rtaddr_e)) ||
                         (i_iss_use_o[2] && (i_iss_rc_o == i_iss_rtaddr_e)) ||
                         (i_iss_wreg_o   && (i_iss_rtaddr_o == i_iss_rtaddr_e)));

    assign w_go_e = (rst != RST_ENABLE) && i_iss_valid_e && !i_hold && !i_flush && !w_haz_e;

    assign w_go_o = (rst != RST_ENABLE) && i_iss_valid_o && !i_hold && !i_flush && !w_haz_o &&
                    (w_go_e || !i_iss_valid_e) && !w_pair_dep;

    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            for (int i = 0; i < NREG; i++) begin
                r_cnt[i] <= '0;
            end
        end else if (i_flush) begin
            for (int i = 0; i < NREG; i++) begin
                r_cnt[i] <= '0;
            end
        end else if (!i_hold) begin
            for (int i = 0; i < NREG; i++) begin
                r_cnt[i] <= (r_cnt[i] != '0) ? r_cnt[i] - 3'd1 : '0;
            end
            // Later assignments win, so a fresh issue overrides the decrement of its destination.
            if (w_go_e && i_iss_wreg_e && (w_lat_e != '0)) begin
                r_cnt[i_iss_rtaddr_e] <= w_lat_e;
            end
            if (w_go_o && i_iss_wreg_o && (w_lat_o != '0)) begin
                r_cnt[i_iss_rtaddr_o] <= w_lat_o;
            end
        end
    end

    assign o_go_e     = w_go_e;
    assign o_go_o     = w_go_o;
    assign o_busy_any = w_busy;

endmodule

// File: tb/tb_spu_issue_scoreboard.sv
// Self-checking bench: directed vector table, directed multi-cycle sequences, then random traffic vs a
// ready-time reference model.
module tb_spu_issue_scoreboard;

    // uid latencies 7,6,3,2,4,2,6,0 so that L=3, L=4 and the untracked L=0 case are all reachable.
    localparam logic [31:0] TB_LAT = 32'h7632_4260;

    logic       clk = 1'b0;
    logic       rst, hold, flush;
    logic       ve, wre, vo, wro;
    logic [6:0] rae, rbe, rce, rte, rao, rbo, rco, rto;
    logic [2:0] use_e, use_o, uid_e, uid_o;
    logic       go_e, go_o, busy;

    always #5 clk = ~clk;

    spu_issue_scoreboard #(.LAT_TABLE(TB_LAT)) u_dut (
        .clk            (clk),
        .rst            (rst),
        .i_hold         (hold),
        .i_flush        (flush),
        .i_iss_valid_e  (ve),
        .i_iss_ra_e     (rae),
        .i_iss_rb_e     (rbe),
        .i_iss_rc_e     (rce),
        .i_iss_use_e    (use_e),
        .i_iss_rtaddr_e (rte),
        .i_iss_wreg_e   (wre),
        .i_iss_uid_e    (uid_e),
        .i_iss_valid_o  (vo),
        .i_iss_ra_o     (rao),
        .i_iss_rb_o     (rbo),
        .i_iss_rc_o     (rco),
        .i_iss_use_o    (use_o),
        .i_iss_rtaddr_o (rto),
        .i_iss_wreg_o   (wro),
        .i_iss_uid_o    (uid_o),
        .o_go_e         (go_e),
        .o_go_o         (go_o),
        .o_busy_any     (busy)
    );

    typedef struct packed {
        logic       v;
        logic [6:0] ra, rb, rc;
        logic [2:0] uf;
        logic [6:0] rt;
        logic       w;
        logic [2:0] uid;
    } slot_t;

    typedef struct packed {
        logic  hold;
        logic  flush;
        slot_t e;
        slot_t o;
        logic  ge, go, busy;
    } vec_t;

    int    checks = 0;
    int    errors = 0;
    vec_t  tbl [25];

    int lat_ref [8] = '{7, 6, 3, 2, 4, 2, 6, 0};
    int rdy [128];
    int tick;

    function automatic slot_t mk(int v, int ra, int rb, int rc, int uf, int rt, int w, int uid);
        slot_t s;
        s.v = 1'(v); s.ra = 7'(ra); s.rb = 7'(rb); s.rc = 7'(rc);
        s.uf = 3'(uf); s.rt = 7'(rt); s.w = 1'(w); s.uid = 3'(uid);
        return s;
    endfunction

    function automatic slot_t nop();
        return '0;
    endfunction

    function automatic slot_t rnd_slot();
        slot_t s;
        s.v   = ($urandom_range(0, 3) != 0);
        s.ra  = 7'($urandom_range(0, 7));
        s.rb  = 7'($urandom_range(0, 7));
        s.rc  = 7'($urandom_range(0, 7));
        s.uf  = 3'($urandom_range(0, 7));
        s.rt  = 7'($urandom_range(0, 7));
        s.w   = ($urandom_range(0, 2) != 0);
        s.uid = 3'($urandom_range(0, 7));
        return s;
    endfunction

    task automatic apply(input logic h, input logic f, input slot_t e, input slot_t o);
        hold = h; flush = f;
        ve = e.v; rae = e.ra; rbe = e.rb; rce = e.rc; use_e = e.uf; rte = e.rt; wre = e.w; uid_e = e.uid;
        vo = o.v; rao = o.ra; rbo = o.rb; rco = o.rc; use_o = o.uf; rto = o.rt; wro = o.w; uid_o = o.uid;
    endtask

    task automatic check(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference model: each register holds the tick at which its result reaches forwarding.
    function automatic int mcnt(int r);
        return (rdy[r] > tick) ? rdy[r] - tick : 0;
    endfunction

    function automatic logic mhaz(slot_t s);
        int l;
        l = lat_ref[s.uid];
        return (s.uf[0] && mcnt(int'(s.ra)) > 0) || (s.uf[1] && mcnt(int'(s.rb)) > 0) ||
               (s.uf[2] && mcnt(int'(s.rc)) > 0) || (s.w && l > 0 && mcnt(int'(s.rt)) > l);
    endfunction

    function automatic logic mdep(slot_t e, slot_t o);
        return e.v && e.w && ((o.uf[0] && o.ra == e.rt) || (o.uf[1] && o.rb == e.rt) ||
                              (o.uf[2] && o.rc == e.rt) || (o.w && o.rt == e.rt));
    endfunction

    function automatic logic mbusy();
        for (int r = 0; r < 128; r++) begin
            if (mcnt(r) > 0) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic count_stalls(output int stalls);
        stalls = 0;
        for (int k = 0; k < 12; k++) begin
            #4;
            if (go_e) break;
            stalls++;
            @(posedge clk); #1;
        end
    endtask

    initial begin
        slot_t e, o;
        logic  r, h, f, ege, ego, eb;
        int    stalls;

        tbl[0]  = '{1'b0, 1'b0, mk(1, 0, 0, 0, 0, 5, 1, 2), nop(), 1'b1, 1'b0, 1'b0};
        tbl[1]  = '{1'b0, 1'b0, mk(1, 5, 0, 0, 1, 0, 0, 0), nop(), 1'b0, 1'b0, 1'b1};
        tbl[2]  = tbl[1];
        tbl[3]  = tbl[1];
        tbl[4]  = '{1'b0, 1'b0, mk(1, 5, 0, 0, 1, 0, 0, 0), nop(), 1'b1, 1'b0, 1'b0};
        tbl[5]  = '{1'b0, 1'b0, mk(1, 0, 0, 0, 0, 9, 1, 2), mk(1, 0, 9, 0, 2, 0, 0, 0), 1'b1, 1'b0, 1'b0};
        tbl[6]  = '{1'b0, 1'b0, nop(), mk(1, 0, 9, 0, 2, 0, 0, 0), 1'b0, 1'b0, 1'b1};
        tbl[7]  = tbl[6];
        tbl[8]  = tbl[6];
        tbl[9]  = '{1'b0, 1'b0, nop(), mk(1, 0, 9, 0, 2, 0, 0, 0), 1'b0, 1'b1, 1'b0};
        tbl[10] = '{1'b0, 1'b0, mk(1, 0, 0, 0, 0, 20, 1, 1), nop(), 1'b1, 1'b0, 1'b0};
        tbl[11] = '{1'b0, 1'b0, mk(1, 20, 0, 0, 1, 0, 0, 0), mk(1, 30, 0, 0, 1, 31, 1, 7), 1'b0, 1'b0, 1'b1};
        tbl[12] = '{1'b0, 1'b0, mk(1, 0, 0, 0, 0, 40, 1, 7), nop(), 1'b1, 1'b0, 1'b1};
        tbl[13] = '{1'b0, 1'b0, mk(1, 40, 0, 0, 1, 0, 0, 0), mk(1, 0, 0, 40, 4, 0, 0, 0), 1'b1, 1'b1, 1'b1};
        tbl[14] = '{1'b0, 1'b0, mk(1, 0, 0, 0, 0, 20, 1, 3), nop(), 1'b0, 1'b0, 1'b1};
        tbl[15] = '{1'b0, 1'b0, mk(1, 0, 0, 0, 0, 20, 1, 3), nop(), 1'b1, 1'b0, 1'b1};
        tbl[16] = '{1'b0, 1'b0, mk(1, 20, 0, 0, 1, 0, 0, 0), nop(), 1'b0, 1'b0, 1'b1};
        tbl[17] = tbl[16];
        tbl[18] = '{1'b0, 1'b0, mk(1, 20, 0, 0, 1, 0, 0, 0), nop(), 1'b1, 1'b0, 1'b0};
        tbl[19] = '{1'b0, 1'b0, mk(1, 0, 0, 0, 0, 50, 1, 7), mk(1, 0, 0, 0, 0, 50, 1, 2), 1'b1, 1'b0, 1'b0};
        tbl[20] = '{1'b0, 1'b0, nop(), mk(1, 0, 0, 0, 0, 50, 1, 2), 1'b0, 1'b1, 1'b0};
        tbl[21] = '{1'b1, 1'b0, mk(1, 50, 0, 0, 1, 0, 0, 0), nop(), 1'b0, 1'b0, 1'b1};
        tbl[22] = tbl[21];
        tbl[23] = '{1'b0, 1'b1, mk(1, 50, 0, 0, 1, 0, 0, 0), nop(), 1'b0, 1'b0, 1'b1};
        tbl[24] = '{1'b0, 1'b0, mk(1, 50, 0, 0, 1, 0, 0, 0), nop(), 1'b1, 1'b0, 1'b0};

        rst = 1'b1;
        apply(1'b0, 1'b0, nop(), nop());

        // Reset holds go low even with valid, hazard-free instructions present.
        @(posedge clk); #1;
        apply(1'b0, 1'b0, mk(1, 1, 2, 3, 7, 4, 1, 0), mk(1, 10, 11, 12, 7, 13, 1, 0));
        #4 check("rst_go_e_c0", go_e, 1'b0); check("rst_go_o_c0", go_o, 1'b0);
        @(posedge clk); #1;
        #4 check("rst_go_e_c1", go_e, 1'b0); check("rst_go_o_c1", go_o, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;
        apply(1'b0, 1'b0, mk(1, 1, 2, 3, 7, 4, 0, 0), mk(1, 10, 11, 12, 7, 13, 0, 0));
        #4 check("post_rst_busy", busy, 1'b0);
        check("post_rst_go_e", go_e, 1'b1); check("post_rst_go_o", go_o, 1'b1);
        @(posedge clk); #1;

        for (int i = 0; i < 25; i++) begin
            apply(tbl[i].hold, tbl[i].flush, tbl[i].e, tbl[i].o);
            #4;
            check($sformatf("vec%0d_go_e", i), go_e, tbl[i].ge);
            check($sformatf("vec%0d_go_o", i), go_o, tbl[i].go);
            check($sformatf("vec%0d_busy", i), busy, tbl[i].busy);
            @(posedge clk); #1;
        end

        // WAW: r12 in flight with 6 left, new writer L=2 waits for counts 6,5,4,3 then lands 2.
        apply(1'b0, 1'b0, mk(1, 0, 0, 0, 0, 12, 1, 1), nop());
        #4 check("waw_first_go", go_e, 1'b1);
        @(posedge clk); #1;
        apply(1'b0, 1'b0, mk(1, 0, 0, 0, 0, 12, 1, 3), nop());
        count_stalls(stalls);
        check_int("waw_stalls", stalls, 4);
        @(posedge clk); #1;
        apply(1'b0, 1'b0, mk(1, 12, 0, 0, 1, 0, 0, 0), nop());
        count_stalls(stalls);
        check_int("waw_new_lat_stalls", stalls, 2);
        @(posedge clk); #1;

        // Hold freezes r3 at 4: after three held cycles the consumer still waits four more.
        apply(1'b0, 1'b0, mk(1, 0, 0, 0, 0, 3, 1, 4), nop());
        #4 check("hold_prod_go", go_e, 1'b1);
        @(posedge clk); #1;
        for (int k = 0; k < 3; k++) begin
            apply(1'b1, 1'b0, mk(1, 3, 0, 0, 1, 0, 0, 0), nop());
            #4 check($sformatf("hold%0d_go_e", k), go_e, 1'b0);
            check($sformatf("hold%0d_busy", k), busy, 1'b1);
            @(posedge clk); #1;
        end
        apply(1'b0, 1'b0, mk(1, 3, 0, 0, 1, 0, 0, 0), nop());
        count_stalls(stalls);
        check_int("hold_frozen_stalls", stalls, 4);
        @(posedge clk); #1;

        // Flush discards tracking: consumer of r3 goes on the very next cycle.
        apply(1'b0, 1'b0, mk(1, 0, 0, 0, 0, 3, 1, 4), nop());
        @(posedge clk); #1;
        apply(1'b0, 1'b1, mk(1, 3, 0, 0, 1, 0, 0, 0), nop());
        #4 check("flush_go_e", go_e, 1'b0);
        @(posedge clk); #1;
        apply(1'b0, 1'b0, mk(1, 3, 0, 0, 1, 0, 0, 0), nop());
        #4 check("after_flush_busy", busy, 1'b0); check("after_flush_go_e", go_e, 1'b1);
        @(posedge clk); #1;

        // Random traffic on a small register window against the ready-time model.
        tick = 0;
        for (int r0 = 0; r0 < 128; r0++) rdy[r0] = 0;
        for (int c = 0; c < 3000; c++) begin
            r = (c == 0) || ($urandom_range(0, 199) == 0);
            h = ($urandom_range(0, 9) == 0);
            f = ($urandom_range(0, 29) == 0);
            e = rnd_slot();
            o = rnd_slot();
            rst = r;
            apply(h, f, e, o);
            ege = !r && e.v && !h && !f && !mhaz(e);
            ego = !r && o.v && !h && !f && !mhaz(o) && (ege || !e.v) && !mdep(e, o);
            eb  = mbusy();
            #4;
            check($sformatf("rnd%0d_go_e", c), go_e, ege);
            check($sformatf("rnd%0d_go_o", c), go_o, ego);
            if (c != 0) check($sformatf("rnd%0d_busy", c), busy, eb);
            @(posedge clk);
            if (r || f) begin
                for (int k = 0; k < 128; k++) rdy[k] = tick;
            end else if (!h) begin
                tick++;
                if (ege && e.w && lat_ref[e.uid] > 0) rdy[e.rt] = tick + lat_ref[e.uid];
                if (ego && o.w && lat_ref[o.uid] > 0) rdy[o.rt] = tick + lat_ref[o.uid];
            end
            #1;
        end
        rst = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
